// File: rtl/conv_study_pkg.sv
// Shared types and sizes for the conv / max_pool / feature SPI chain.
// A feature vector packs element 0 at the most-significant byte.
package conv_study_pkg;

   localparam int NUM_FEATURES = 6;
   localparam int FEATURE_W    = 8;
   localparam int FRAME_BITS   = NUM_FEATURES * FEATURE_W;

   typedef logic signed [0:NUM_FEATURES-1][FEATURE_W-1:0] feature_vec_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD,
      GAP
   } spi_state_t;

   // Serial order on the wire is f0[7] first through f5[0] last.
   function automatic logic [FRAME_BITS-1:0] pack_frame(input feature_vec_t v);
      logic [FRAME_BITS-1:0] r_res;
      r_res = '0;
      for (int i = 0; i < NUM_FEATURES; i++) begin
         r_res[FRAME_BITS-1-i*FEATURE_W -: FEATURE_W] = v[i];
      end
      return r_res;
   endfunction

endpackage

// File: rtl/feature_vec_fifo.sv
// Single-clock FIFO of packed feature frames with full/empty flags.
// No bypass: data pushed in one cycle is visible at the read port the next.
module feature_vec_fifo
   import conv_study_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = FRAME_BITS
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CNT_MAX);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/feature_spi_tx.sv
// Buffers feature vectors and sends each as one 48-bit SPI mode-0 frame,
// followed by a hold period and an inter-frame gap with chip select high.
module feature_spi_tx
   import conv_study_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_feature_valid,
   input  feature_vec_t i_features,
   output logic         o_ready,
   output logic         o_sclk,
   output logic         o_cs_n,
   output logic         o_mosi,
   output logic         o_busy,
   output logic         o_frame_done
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [FRAME_BITS-1:0] w_frame_in;
   logic [FRAME_BITS-1:0] w_fifo_data;

   spi_state_t            r_state;
   logic [FRAME_BITS-1:0] r_shift;
   logic [7:0]            r_div;
   logic [5:0]            r_bit;
   logic                  r_sclk;
   logic                  r_cs_n;
   logic                  r_busy;
   logic                  r_frame_done;

   assign o_ready    = !w_full;
   assign w_push     = i_feature_valid && o_ready;
   assign w_pop      = (r_state == IDLE) && !w_empty;
   assign w_frame_in = pack_frame(i_features);

   feature_vec_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FRAME_BITS)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (w_frame_in),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // MOSI is the shifter MSB; clearing the shifter keeps MOSI low outside frames.
   assign o_mosi       = r_shift[FRAME_BITS-1];
   assign o_sclk       = r_sclk;
   assign o_cs_n       = r_cs_n;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_div        <= '0;
         r_bit        <= '0;
         r_sclk       <= 1'b0;
         r_cs_n       <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_div  <= '0;
               r_bit  <= '0;
               r_sclk <= 1'b0;
               if (!w_empty) begin
                  r_shift <= w_fifo_data;
                  r_cs_n  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (r_div == DIV_LAST) begin
                  r_div <= '0;
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                  end else begin
                     r_sclk <= 1'b0;
                     if (r_bit == LAST_BIT) begin
                        r_shift <= '0;
                        r_bit   <= '0;
                        r_state <= HOLD;
                     end else begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        r_bit   <= r_bit + 6'd1;
                     end
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            HOLD: begin
               if (r_div == DIV_LAST) begin
                  r_div        <= '0;
                  r_cs_n       <= 1'b1;
                  r_frame_done <= 1'b1;
                  r_state      <= GAP;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            GAP: begin
               // Two divider periods, tracked in r_bit[0] so the 8-bit divider never overflows.
               if (r_div == DIV_LAST) begin
                  r_div <= '0;
                  if (r_bit[0]) begin
                     r_bit   <= '0;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_bit <= 6'd1;
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/feature_spi_tx.md
FEATURE_SPI_TX -- requirements
Module: feature_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in i_clk cycles; legal values are 2 to 255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: feature vectors buffered; must be a power of 2, at least 2.
REQ-003 SHALL have port i_clk  in  1  system clock (clk200m domain); the block uses one clock.
REQ-004 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_feature_valid  in  1  feature vector valid, from max_pool/post-processing.
REQ-006 SHALL have port i_features  in  6x8 signed  feature vector, elements [0:5].
REQ-007 SHALL have port o_ready  out  1  vector accepted this cycle when high together with i_feature_valid.
REQ-008 SHALL have port o_sclk  out  1  SPI clock, mode 0 (idles low).
REQ-009 SHALL have port o_cs_n  out  1  SPI chip select, active-low, one frame per vector.
REQ-010 SHALL have port o_mosi  out  1  SPI serial data.
REQ-011 SHALL have port o_busy  out  1  high while a frame is in progress (o_cs_n low) or during the inter-frame gap.
REQ-012 SHALL have port o_frame_done  out  1  one-cycle pulse in the cycle o_cs_n returns high.

Function
REQ-013 SHALL drive o_ready = !fifo_full, combinationally; a push occurs only when i_feature_valid && o_ready.
REQ-014 SHALL ignore i_features when i_feature_valid is low; no data is dropped while o_ready is high.
REQ-015 SHALL use FSM states IDLE, SHIFT, HOLD, GAP; reset state is IDLE.
REQ-016 In IDLE with FIFO non-empty at cycle t: SHALL pop one vector, load the 48-bit shift register {f0,f1,...,f5}, and at t+1 drive o_cs_n=0 and o_mosi=bit47 (f0 MSB); state goes to SHIFT.
REQ-017 A vector pushed into an empty FIFO at cycle t SHALL be popped no earlier than t+1; there is no bypass path.
REQ-018 In SHIFT, o_sclk SHALL toggle every CLK_DIV cycles: rising edges at t+1+CLK_DIV*(2k+1) and falling edges at t+1+CLK_DIV*(2k+2), for k=0..47.
REQ-019 o_mosi SHALL change only on falling edges of o_sclk, advancing one bit MSB-first; bit order is f0[7] through f5[0].
REQ-020 After the 48th falling edge the state SHALL go to HOLD with o_sclk low, held for CLK_DIV cycles; o_cs_n SHALL go high at t+1+97*CLK_DIV, and o_frame_done pulses in that same cycle.
REQ-021 GAP SHALL keep o_cs_n high for 2*CLK_DIV cycles, then return to IDLE; back-to-back frames have o_cs_n high for at least 2*CLK_DIV+1 cycles.
REQ-022 o_mosi SHALL be 0 whenever o_cs_n is high.
REQ-023 Bit counter SHALL be 6 bits (0..47); divider counter SHALL be 8 bits; neither wraps mid-frame.
REQ-024 A simultaneous push and pop SHALL be legal, leaving the FIFO count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-025 A full FIFO SHALL hold o_ready low; the in-progress frame SHALL continue unaffected.

Reset
REQ-026 Asserting i_rst SHALL immediately force o_cs_n=1, o_sclk=0, o_mosi=0, o_busy=0 and o_frame_done=0, with state IDLE.
REQ-027 Asserting i_rst SHALL empty the FIFO, so o_ready=1 after reset.
REQ-028 A reset during a frame SHALL abort the frame without an o_frame_done pulse; buffered vectors are discarded.

Structure
REQ-029 NUM_FEATURES=6, FEATURE_W=8, FRAME_BITS=48 and typedef feature_vec_t (signed [7:0] x6) SHALL live in conv_study_pkg, shared with conv and max_pool.
REQ-030 The FIFO SHALL be a sub-module feature_vec_fifo (sync, single clock, async reset, full/empty flags); the FSM and shifter live in feature_spi_tx.

Verification
REQ-031 Single vector {0x81,0x7F,0x00,0xFF,0x55,0xAA}, CLK_DIV=4 -> o_cs_n low for exactly 388 cycles; 48 rising edges sampled by the SPI model yield 81 7F 00 FF 55 AA; one o_frame_done pulse.
REQ-032 Five vectors pushed on consecutive cycles, FIFO_DEPTH=4 -> o_ready low on the 5th cycle only after 4 unpopped pushes; all accepted vectors are transmitted in order, with each gap of o_cs_n high at least 9 cycles.
REQ-033 Push into an empty FIFO at cycle t -> o_cs_n falls at t+2, with o_mosi equal to the f0 MSB in that cycle.
REQ-034 i_rst asserted at the 20th rising SCLK edge with 2 vectors queued -> outputs are immediately idle, there is no o_frame_done, and o_ready=1; a new vector afterwards transmits correctly.
REQ-035 Random valid/ready traffic of 200 vectors, CLK_DIV=2 -> the scoreboard matches all vectors, and o_mosi is stable while o_sclk is high.
